// File: rtl/connect4_game_controller.sv
// Connect4 turn/game-state sequencer: validates drops, issues placements,
// and resolves win/tie from the external checker's verdict.
module connect4_game_controller #(
  parameter int COLS      = 7,
  parameter int ROWS      = 6,
  parameter int MAX_MOVES = 42
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       drop,
  input  logic [2:0] column,
  input  logic       win_valid,
  input  logic       win_detected,
  output logic [1:0] state,
  output logic [1:0] game_status,
  output logic       place_valid,
  output logic [2:0] place_col,
  output logic [2:0] place_row,
  output logic       place_player,
  output logic       illegal_move,
  output logic [5:0] move_count
);

  typedef enum logic [2:0] {S_INIT, S_P1, S_P2, S_CHECK, S_END} fsm_t;

  fsm_t       fsm_q, fsm_d;
  logic       cur_player_q, cur_player_d;
  logic [1:0] state_q, state_d;
  logic [1:0] game_status_q, game_status_d;
  logic       place_valid_q, place_valid_d;
  logic [2:0] place_col_q, place_col_d;
  logic [2:0] place_row_q, place_row_d;
  logic       place_player_q, place_player_d;
  logic       illegal_move_q, illegal_move_d;
  logic [5:0] move_count_q, move_count_d;
  logic [2:0] height_q [COLS];
  logic [2:0] height_d [COLS];
  logic [2:0] col_h;
  logic       legal;

  always_comb begin
    fsm_d          = fsm_q;
    cur_player_d   = cur_player_q;
    game_status_d  = game_status_q;
    place_valid_d  = 1'b0;
    place_col_d    = place_col_q;
    place_row_d    = place_row_q;
    place_player_d = place_player_q;
    illegal_move_d = 1'b0;
    move_count_d   = move_count_q;
    height_d       = height_q;

    // Loop select keeps out-of-range columns from indexing past the array.
    col_h = 3'd0;
    for (int i = 0; i < COLS; i++)
      if (column == 3'(i)) col_h = height_q[i];
    legal = ({1'b0, column} < 4'(COLS)) && (col_h < 3'(ROWS));

    case (fsm_q)
      S_INIT: begin
        if (start) begin
          fsm_d        = S_P1;
          cur_player_d = 1'b0;
          move_count_d = 6'd0;
          for (int i = 0; i < COLS; i++) height_d[i] = 3'd0;
        end
      end
      S_P1, S_P2: begin
        if (drop) begin
          if (legal) begin
            place_valid_d  = 1'b1;
            place_col_d    = column;
            place_row_d    = col_h;
            place_player_d = (fsm_q == S_P2);
            cur_player_d   = (fsm_q == S_P2);
            move_count_d   = move_count_q + 6'd1;
            for (int i = 0; i < COLS; i++)
              if (column == 3'(i)) height_d[i] = height_q[i] + 3'd1;
            fsm_d = S_CHECK;
          end else begin
            illegal_move_d = 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (win_valid) begin
          if (win_detected) begin
            fsm_d         = S_END;
            game_status_d = cur_player_q ? 2'b10 : 2'b01;
          end else if (move_count_q == 6'(MAX_MOVES)) begin
            fsm_d         = S_END;
            game_status_d = 2'b11;
          end else begin
            fsm_d = cur_player_q ? S_P1 : S_P2;
          end
        end
      end
      S_END: begin
        if (start) begin
          fsm_d         = S_INIT;
          game_status_d = 2'b00;
          move_count_d  = 6'd0;
          for (int i = 0; i < COLS; i++) height_d[i] = 3'd0;
        end
      end
      default: fsm_d = S_INIT;
    endcase

    // CHECK shows the turn of the player being checked, so no transient code.
    case (fsm_d)
      S_P1:    state_d = 2'b01;
      S_P2:    state_d = 2'b10;
      S_CHECK: state_d = cur_player_d ? 2'b10 : 2'b01;
      S_END:   state_d = 2'b11;
      default: state_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q          <= S_INIT;
      cur_player_q   <= 1'b0;
      state_q        <= 2'b00;
      game_status_q  <= 2'b00;
      place_valid_q  <= 1'b0;
      place_col_q    <= 3'd0;
      place_row_q    <= 3'd0;
      place_player_q <= 1'b0;
      illegal_move_q <= 1'b0;
      move_count_q   <= 6'd0;
      for (int i = 0; i < COLS; i++) height_q[i] <= 3'd0;
    end else begin
      fsm_q          <= fsm_d;
      cur_player_q   <= cur_player_d;
      state_q        <= state_d;
      game_status_q  <= game_status_d;
      place_valid_q  <= place_valid_d;
      place_col_q    <= place_col_d;
      place_row_q    <= place_row_d;
      place_player_q <= place_player_d;
      illegal_move_q <= illegal_move_d;
      move_count_q   <= move_count_d;
      for (int i = 0; i < COLS; i++) height_q[i] <= height_d[i];
    end
  end

  assign state        = state_q;
  assign game_status  = game_status_q;
  assign place_valid  = place_valid_q;
  assign place_col    = place_col_q;
  assign place_row    = place_row_q;
  assign place_player = place_player_q;
  assign illegal_move = illegal_move_q;
  assign move_count   = move_count_q;

endmodule

// File: tb/tb_connect4_game_controller.sv
// Bench for connect4_game_controller: queued expected placement/illegal events
// checked by a monitor, plus direct state/status/count checks.
module tb_connect4_game_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, drop = 1'b0, win_valid = 1'b0, win_detected = 1'b0;
  logic [2:0] column = 3'd0;
  logic [1:0] state, game_status;
  logic       place_valid, place_player, illegal_move;
  logic [2:0] place_col, place_row;
  logic [5:0] move_count;

  typedef struct packed {
    logic       illegal;
    logic [2:0] col;
    logic [2:0] row;
    logic       player;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  connect4_game_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .drop(drop), .column(column),
    .win_valid(win_valid), .win_detected(win_detected),
    .state(state), .game_status(game_status), .place_valid(place_valid),
    .place_col(place_col), .place_row(place_row), .place_player(place_player),
    .illegal_move(illegal_move), .move_count(move_count)
  );

  always #5 clk = ~clk;

  // Monitor: every output event must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (place_valid || illegal_move)) begin
      ev_t got, e;
      got = '{illegal: illegal_move, col: place_col, row: place_row, player: place_player};
      n_vec++;
      if (place_valid && illegal_move) begin
        n_err++;
        $display("FAIL event: place_valid and illegal_move both high");
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL event: unexpected output got=%h", got);
      end else begin
        e = exp_q.pop_front();
        if (got.illegal !== e.illegal ||
            (!e.illegal && (got.col !== e.col || got.row !== e.row || got.player !== e.player))) begin
          n_err++;
          $display("FAIL event: got ill=%0b col=%0d row=%0d pl=%0b exp ill=%0b col=%0d row=%0d pl=%0b",
                   got.illegal, got.col, got.row, got.player, e.illegal, e.col, e.row, e.player);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_drop(input int col, input bit legal, input int row, input bit player);
    ev_t e;
    e = '{illegal: !legal, col: 3'(col), row: 3'(row), player: player};
    exp_q.push_back(e);
    @(negedge clk); drop = 1'b1; column = 3'(col);
    @(negedge clk); drop = 1'b0;
  endtask

  task automatic verdict(input bit win);
    @(negedge clk); win_valid = 1'b1; win_detected = win;
    @(negedge clk); win_valid = 1'b0; win_detected = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  // Fills the board column by column; last move's verdict is last_win.
  task automatic fill_board(input bit last_win);
    for (int k = 0; k < 42; k++) begin
      do_drop(k / 6, 1'b1, k % 6, k[0]);
      chk("fill_mc", move_count, k + 1);
      verdict((k == 41) ? last_win : 1'b0);
      if (k < 41) chk("fill_turn", state, k[0] ? 1 : 2);
    end
  endtask

  initial begin
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_status", game_status, 0);
    chk("rst_mc", move_count, 0);
    chk("rst_pv", place_valid, 0);
    do_drop(0, 1'b0, 0, 1'b0);
    exp_q.delete();
    chk("init_drop_ignored", state, 0);

    // Basic turn.
    pulse_start();
    chk("start_state", state, 1);
    chk("start_status", game_status, 0);
    do_drop(3, 1'b1, 0, 1'b0);
    chk("check_state", state, 1);
    chk("check_mc", move_count, 1);
    pulse_start();
    chk("check_start_ignored", state, 1);
    verdict(1'b0);
    chk("p2_turn", state, 2);

    // Column fill and illegal drops.
    do_reset();
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      do_drop(0, 1'b1, k, k[0]);
      verdict(1'b0);
    end
    do_drop(0, 1'b0, 0, 1'b0);
    chk("full_mc", move_count, 6);
    chk("full_state", state, 1);
    do_drop(7, 1'b0, 0, 1'b0);
    chk("col7_mc", move_count, 6);
    chk("col7_state", state, 1);
    do_drop(1, 1'b1, 0, 1'b0);
    verdict(1'b0);
    do_drop(1, 1'b1, 1, 1'b1);
    verdict(1'b1);
    chk("p2win_state", state, 3);
    chk("p2win_status", game_status, 2);
    chk("end_mc_hold", move_count, 8);
    pulse_start();
    chk("end_start_state", state, 0);
    chk("end_start_status", game_status, 0);
    chk("end_start_mc", move_count, 0);
    pulse_start();
    chk("restart_state", state, 1);

    // Tie, then win on the last move.
    fill_board(1'b0);
    chk("tie_state", state, 3);
    chk("tie_status", game_status, 3);
    pulse_start();
    pulse_start();
    fill_board(1'b1);
    chk("lastwin_state", state, 3);
    chk("lastwin_status", game_status, 2);

    // Reset during CHECK; late verdict ignored.
    pulse_start();
    pulse_start();
    do_drop(5, 1'b1, 0, 1'b0);
    do_reset();
    verdict(1'b1);
    chk("rstchk_state", state, 0);
    chk("rstchk_status", game_status, 0);
    chk("rstchk_mc", move_count, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
